// File: rtl/seg7_digit_capture_if.sv
// Bus between a multiplexed two-digit 7-segment source and the capture block.
// The source (master) drives the segment bus and digit select; the capture block (slave) returns the published digits and pulses.
interface seg7_digit_capture_if;
   logic [6:0] Segments;
   logic       Digit_Sel;
   logic [3:0] Sec1;
   logic [3:0] Sec0;
   logic       Value_Valid;
   logic       Value_Changed;
   logic       Code_Error;

   modport master (
      output Segments, Digit_Sel,
      input  Sec1, Sec0, Value_Valid, Value_Changed, Code_Error
   );

   modport slave (
      input  Segments, Digit_Sel,
      output Sec1, Sec0, Value_Valid, Value_Changed, Code_Error
   );
endinterface

// File: rtl/seg7_digit_capture.sv
// Debounces a multiplexed 7-segment bus, decodes each digit to BCD and
// publishes a {tens, ones} seconds pair once both digits are freshly captured.
module seg7_digit_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input logic                  Clock,
   input logic                  Reset,
   seg7_digit_capture_if.slave  bus
);

   localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [7:0]       sample_q, sample_d;
   logic             first_q, first_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accepted_q, accepted_d;
   logic [3:0]       shadow1_q, shadow1_d;
   logic [3:0]       shadow0_q, shadow0_d;
   logic             fresh1_q, fresh1_d;
   logic             fresh0_q, fresh0_d;
   logic [3:0]       sec1_q, sec1_d;
   logic [3:0]       sec0_q, sec0_d;
   logic             valid_q, valid_d;
   logic             changed_q, changed_d;
   logic             error_q, error_d;

   logic [7:0]       sample_cur;
   logic             sample_change;
   logic             accept;
   logic             legal;
   logic [3:0]       bcd;

   assign sample_cur = {bus.Digit_Sel, bus.Segments};

   always_comb begin
      legal = 1'b1;
      bcd   = 4'd0;
      case (sample_cur[6:0])
         7'b0111111: bcd = 4'd0;
         7'b0000110: bcd = 4'd1;
         7'b1011011: bcd = 4'd2;
         7'b1001111: bcd = 4'd3;
         7'b1100110: bcd = 4'd4;
         7'b1101101: bcd = 4'd5;
         7'b1111100,
         7'b1111101: bcd = 4'd6;
         7'b0000111: bcd = 4'd7;
         7'b1111111: bcd = 4'd8;
         7'b1100111,
         7'b1101111: bcd = 4'd9;
         default:    legal = 1'b0;
      endcase
   end

   always_comb begin
      sample_d   = sample_cur;
      first_d    = 1'b0;
      cnt_d      = cnt_q;
      accepted_d = accepted_q;
      shadow1_d  = shadow1_q;
      shadow0_d  = shadow0_q;
      fresh1_d   = fresh1_q;
      fresh0_d   = fresh0_q;
      sec1_d     = sec1_q;
      sec0_d     = sec0_q;
      valid_d    = 1'b0;
      changed_d  = 1'b0;
      error_d    = 1'b0;

      // The first sample after reset always opens a new episode, even if it is all zero.
      sample_change = first_q || (sample_cur != sample_q);

      if (sample_change) begin
         cnt_d      = CNT_ONE;
         accepted_d = 1'b0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      accept = !sample_change && !accepted_q && (cnt_d == CNT_MAX);

      if (accept) begin
         accepted_d = 1'b1;
         if (legal) begin
            if (sample_cur[7]) begin
               shadow1_d = bcd;
               fresh1_d  = 1'b1;
            end else begin
               shadow0_d = bcd;
               fresh0_d  = 1'b1;
            end
         end else begin
            error_d = 1'b1;
            if (sample_cur[7]) fresh1_d = 1'b0;
            else               fresh0_d = 1'b0;
         end
      end

      if (accept && legal && fresh1_d && fresh0_d) begin
         sec1_d    = shadow1_d;
         sec0_d    = shadow0_d;
         valid_d   = 1'b1;
         changed_d = ({shadow1_d, shadow0_d} != {sec1_q, sec0_q});
         fresh1_d  = 1'b0;
         fresh0_d  = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sample_q   <= '0;
         first_q    <= 1'b1;
         cnt_q      <= '0;
         accepted_q <= 1'b0;
         shadow1_q  <= '0;
         shadow0_q  <= '0;
         fresh1_q   <= 1'b0;
         fresh0_q   <= 1'b0;
         sec1_q     <= '0;
         sec0_q     <= '0;
         valid_q    <= 1'b0;
         changed_q  <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         sample_q   <= sample_d;
         first_q    <= first_d;
         cnt_q      <= cnt_d;
         accepted_q <= accepted_d;
         shadow1_q  <= shadow1_d;
         shadow0_q  <= shadow0_d;
         fresh1_q   <= fresh1_d;
         fresh0_q   <= fresh0_d;
         sec1_q     <= sec1_d;
         sec0_q     <= sec0_d;
         valid_q    <= valid_d;
         changed_q  <= changed_d;
         error_q    <= error_d;
      end
   end

   assign bus.Sec1          = sec1_q;
   assign bus.Sec0          = sec0_q;
   assign bus.Value_Valid   = valid_q;
   assign bus.Value_Changed = changed_q;
   assign bus.Code_Error    = error_q;

endmodule

// File: tb/tb_seg7_digit_capture.sv
// Scoreboard bench for seg7_digit_capture: directed segment holds push expected
// publish/error events; a negedge monitor pops and compares them.
module tb_seg7_digit_capture;

   localparam int S  = 4;
   localparam int KN = 0;
   localparam int KV = 1;
   localparam int KE = 2;

   typedef struct {
      int         kind;
      logic [3:0] s1;
      logic [3:0] s0;
      logic       chg;
      int         due;
   } exp_t;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q[$];

   seg7_digit_capture_if bus();

   seg7_digit_capture #(.STABLE_CYCLES(S)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hold a pattern for n sample edges; an expected event is due S-1 edges after the first sample.
   task automatic step(input logic sel, input logic [6:0] seg, input int n, input int kind,
                       input logic [3:0] s1, input logic [3:0] s0, input logic chg);
      exp_t e;
      @(negedge Clock);
      bus.Digit_Sel = sel;
      bus.Segments  = seg;
      if (kind != KN) begin
         e.kind = kind; e.s1 = s1; e.s0 = s0; e.chg = chg; e.due = cyc + S;
         q.push_back(e);
      end
      repeat (n) @(posedge Clock);
   endtask

   task automatic sec_chk(input string name, input int s1, input int s0);
      @(negedge Clock);
      chk({name, "_sec1"}, int'(bus.Sec1), s1);
      chk({name, "_sec0"}, int'(bus.Sec0), s0);
   endtask

   task automatic zero_chk(input string name);
      chk({name, "_sec1"}, int'(bus.Sec1), 0);
      chk({name, "_sec0"}, int'(bus.Sec0), 0);
      chk({name, "_valid"}, int'(bus.Value_Valid), 0);
      chk({name, "_changed"}, int'(bus.Value_Changed), 0);
      chk({name, "_error"}, int'(bus.Code_Error), 0);
   endtask

   always @(negedge Clock) begin
      exp_t e;
      if (bus.Value_Valid || bus.Code_Error) begin
         chk("valid_error_exclusive", int'(bus.Value_Valid && bus.Code_Error), 0);
         if (q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            e = q.pop_front();
            chk("event_cycle", cyc, e.due);
            chk("event_kind", bus.Code_Error ? KE : KV, e.kind);
            chk("event_sec1", int'(bus.Sec1), int'(e.s1));
            chk("event_sec0", int'(bus.Sec0), int'(e.s0));
            chk("event_value_changed", int'(bus.Value_Changed), int'(e.chg));
         end
      end else begin
         if (bus.Value_Changed) chk("changed_without_valid", 1, 0);
         if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            chk("missed_event_due", cyc, e.due);
         end
      end
   end

   initial begin
      bus.Segments  = 7'b0;
      bus.Digit_Sel = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      zero_chk("reset");
      Reset = 1'b0;

      // 42: tens then ones
      step(1'b1, 7'b1100110, 4, KN, 4'd0, 4'd0, 1'b0);
      step(1'b0, 7'b1011011, 4, KV, 4'd4, 4'd2, 1'b1);
      sec_chk("pub42", 4, 2);

      // ones held only S-1 samples, then tens overwritten; no publish
      step(1'b1, 7'b1100110, 4, KN, 4'd0, 4'd0, 1'b0);
      step(1'b0, 7'b0111111, 3, KN, 4'd0, 4'd0, 1'b0);
      step(1'b1, 7'b0000110, 4, KN, 4'd0, 4'd0, 1'b0);
      sec_chk("short_hold", 4, 2);
      step(1'b0, 7'b1011011, 4, KV, 4'd1, 4'd2, 1'b1);

      // illegal ones code clears ones fresh bit; tens alone must not publish
      step(1'b0, 7'b0000110, 4, KN, 4'd0, 4'd0, 1'b0);
      step(1'b0, 7'b0000001, 4, KE, 4'd1, 4'd2, 1'b0);
      step(1'b1, 7'b1100110, 4, KN, 4'd0, 4'd0, 1'b0);
      sec_chk("after_error", 1, 2);
      step(1'b0, 7'b1011011, 4, KV, 4'd4, 4'd2, 1'b1);

      // republish 42 with a long ones hold: one accept, no change
      step(1'b1, 7'b1100110, 4, KN, 4'd0, 4'd0, 1'b0);
      step(1'b0, 7'b1011011, 50, KV, 4'd4, 4'd2, 1'b0);

      // 69 with both encodings of 6 and 9
      step(1'b1, 7'b1111101, 4, KN, 4'd0, 4'd0, 1'b0);
      step(1'b0, 7'b1101111, 4, KV, 4'd6, 4'd9, 1'b1);
      step(1'b1, 7'b1111100, 4, KN, 4'd0, 4'd0, 1'b0);
      step(1'b0, 7'b1100111, 4, KV, 4'd6, 4'd9, 1'b0);
      sec_chk("pub69", 6, 9);

      // reset on the 3rd cycle of a ones hold after tens was captured
      step(1'b1, 7'b0000110, 4, KN, 4'd0, 4'd0, 1'b0);
      step(1'b0, 7'b0111111, 2, KN, 4'd0, 4'd0, 1'b0);
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      zero_chk("mid_reset");
      Reset = 1'b0;
      step(1'b0, 7'b0111111, 4, KN, 4'd0, 4'd0, 1'b0);
      sec_chk("post_reset_ones", 0, 0);
      step(1'b1, 7'b0000110, 4, KV, 4'd1, 4'd0, 1'b1);
      sec_chk("pub10", 1, 0);

      repeat (10) @(negedge Clock);
      chk("pending_events", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
